// File: rtl/wb_stage_hs.sv
// Write-back stage with valid/ready handshake, load-data wait state and retire counter.
// Optional DIFFTEST_EN adds registered commit-trace outputs aligned with retire_o.
module wb_stage_hs #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] alures_i,
    input  logic            lsres_valid_i,
    input  logic [XLEN-1:0] lsres_i,
    output logic [4:0]      rd_idx_o,
    output logic            rd_wren_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            retire_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] instret_o
`ifdef DIFFTEST_EN
    ,
    output logic            commit_valid_o,
    output logic [XLEN-1:0] commit_pc_o,
    output logic [ILEN-1:0] commit_instr_o,
    output logic [4:0]      commit_rd_o,
    output logic [XLEN-1:0] commit_data_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACT  = 2'd2
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    function automatic logic op_writes_alu(input logic [4:0] op);
        case (op)
            5'b01100, 5'b01110, 5'b00100, 5'b00110,
            5'b11011, 5'b11001, 5'b01101, 5'b00101: op_writes_alu = 1'b1;
            default:                                op_writes_alu = 1'b0;
        endcase
    endfunction

    function automatic logic op_known(input logic [4:0] op);
        op_known = op_writes_alu(op) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    state_t          state_r, state_s;
    logic            accept_s, load_in_s, lsres_take_s;
    logic [XLEN-1:0] pc_r, pc_s, alures_r, alures_s, lsres_r, lsres_s;
    logic [ILEN-1:0] instr_r, instr_s;
    logic [4:0]      op_s;
    logic            act_s, wren_s, illegal_s;
    logic [XLEN-1:0] data_s;
    logic            rd_wren_r, retire_r, illegal_r;
    logic [4:0]      rd_idx_r;
    logic [XLEN-1:0] rd_data_r, instret_r;

    assign ready_o      = (state_r != ST_WAIT);
    assign accept_s     = valid_i & ready_o;
    assign load_in_s    = (instr_i[6:2] == OP_LOAD);
    // Load data is only taken while waiting, or alongside the load's own accept.
    assign lsres_take_s = lsres_valid_i & ((state_r == ST_WAIT) | (accept_s & load_in_s));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_ACT: begin
                if (accept_s) begin
                    state_s = (load_in_s && !lsres_valid_i) ? ST_WAIT : ST_ACT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lsres_valid_i) begin
                    state_s = ST_ACT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the held instruction registers.
    always_comb begin
        pc_s     = pc_r;
        instr_s  = instr_r;
        alures_s = alures_r;
        lsres_s  = lsres_r;
        if (accept_s) begin
            pc_s     = pc_i;
            instr_s  = instr_i;
            alures_s = alures_i;
        end else begin
            pc_s     = pc_r;
            instr_s  = instr_r;
            alures_s = alures_r;
        end
        if (lsres_take_s) begin
            lsres_s = lsres_i;
        end else begin
            lsres_s = lsres_r;
        end
    end

    // Output logic: register-file/retire values for the cycle after this edge.
    always_comb begin
        op_s      = instr_s[6:2];
        act_s     = (state_s == ST_ACT);
        wren_s    = 1'b0;
        illegal_s = 1'b0;
        data_s    = {XLEN{1'b0}};
        if (act_s) begin
            wren_s    = (op_writes_alu(op_s) || (op_s == OP_LOAD)) && (instr_s[11:7] != 5'd0);
            illegal_s = !op_known(op_s);
            data_s    = (op_s == OP_LOAD) ? lsres_s : alures_s;
        end else begin
            wren_s    = 1'b0;
            illegal_s = 1'b0;
            data_s    = {XLEN{1'b0}};
        end
    end

    // Held registers, registered outputs and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= {XLEN{1'b0}};
            instr_r   <= {ILEN{1'b0}};
            alures_r  <= {XLEN{1'b0}};
            lsres_r   <= {XLEN{1'b0}};
            rd_wren_r <= 1'b0;
            rd_idx_r  <= 5'd0;
            rd_data_r <= {XLEN{1'b0}};
            retire_r  <= 1'b0;
            illegal_r <= 1'b0;
            instret_r <= {XLEN{1'b0}};
        end else begin
            pc_r      <= pc_s;
            instr_r   <= instr_s;
            alures_r  <= alures_s;
            lsres_r   <= lsres_s;
            rd_wren_r <= wren_s;
            rd_idx_r  <= instr_s[11:7];
            rd_data_r <= data_s;
            retire_r  <= act_s;
            illegal_r <= illegal_s;
            instret_r <= instret_r + (retire_r ? {{(XLEN-1){1'b0}}, 1'b1} : {XLEN{1'b0}});
        end
    end

    assign rd_wren_o = rd_wren_r;
    assign rd_idx_o  = rd_idx_r;
    assign rd_data_o = rd_data_r;
    assign retire_o  = retire_r;
    assign illegal_o = illegal_r;
    assign instret_o = instret_r;

`ifdef DIFFTEST_EN
    logic            commit_valid_r;
    logic [XLEN-1:0] commit_pc_r, commit_data_r;
    logic [ILEN-1:0] commit_instr_r;
    logic [4:0]      commit_rd_r;

    // Commit trace, zero whenever nothing retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid_r <= 1'b0;
            commit_pc_r    <= {XLEN{1'b0}};
            commit_instr_r <= {ILEN{1'b0}};
            commit_rd_r    <= 5'd0;
            commit_data_r  <= {XLEN{1'b0}};
        end else if (act_s) begin
            commit_valid_r <= 1'b1;
            commit_pc_r    <= pc_s;
            commit_instr_r <= instr_s;
            commit_rd_r    <= instr_s[11:7];
            commit_data_r  <= data_s;
        end else begin
            commit_valid_r <= 1'b0;
            commit_pc_r    <= {XLEN{1'b0}};
            commit_instr_r <= {ILEN{1'b0}};
            commit_rd_r    <= 5'd0;
            commit_data_r  <= {XLEN{1'b0}};
        end
    end

    assign commit_valid_o = commit_valid_r;
    assign commit_pc_o    = commit_pc_r;
    assign commit_instr_o = commit_instr_r;
    assign commit_rd_o    = commit_rd_r;
    assign commit_data_o  = commit_data_r;
`else
    logic unused_trace_s;
    assign unused_trace_s = ^{pc_r, instr_r[ILEN-1:12], instr_r[1:0]};
`endif

endmodule

// File: tb/tb_wb_stage_hs.sv
// Self-checking bench for wb_stage_hs: directed scenarios plus randomized traffic
// against a behavioural model. Commit-trace checks are compiled in with DIFFTEST_EN.
module tb_wb_stage_hs;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, valid_i, lsres_valid_i;
    logic [XLEN-1:0] pc_i, alures_i, lsres_i;
    logic [ILEN-1:0] instr_i;
    logic            ready_o, rd_wren_o, retire_o, illegal_o;
    logic [4:0]      rd_idx_o;
    logic [XLEN-1:0] rd_data_o, instret_o;

    logic            w_rst, w_valid, w_lsv;
    logic [7:0]      w_pc, w_alu, w_lsres;
    logic [31:0]     w_instr;
    logic            w_ready, w_wren, w_retire, w_illegal;
    logic [4:0]      w_idx;
    logic [7:0]      w_data, w_instret;

`ifdef DIFFTEST_EN
    logic            commit_valid_o;
    logic [XLEN-1:0] commit_pc_o, commit_data_o;
    logic [ILEN-1:0] commit_instr_o;
    logic [4:0]      commit_rd_o;
    logic            w_cv;
    logic [7:0]      w_cpc, w_cdata;
    logic [31:0]     w_cinstr;
    logic [4:0]      w_crd;
`endif

    int total = 0;
    int bad   = 0;

    wb_stage_hs #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
        .instr_i(instr_i), .alures_i(alures_i), .lsres_valid_i(lsres_valid_i),
        .lsres_i(lsres_i), .rd_idx_o(rd_idx_o), .rd_wren_o(rd_wren_o),
        .rd_data_o(rd_data_o), .retire_o(retire_o), .illegal_o(illegal_o),
        .instret_o(instret_o)
`ifdef DIFFTEST_EN
        , .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
        .commit_instr_o(commit_instr_o), .commit_rd_o(commit_rd_o),
        .commit_data_o(commit_data_o)
`endif
    );

    // Narrow instance so the retire counter can be wrapped in a few hundred cycles.
    wb_stage_hs #(.XLEN(8), .ILEN(32)) dut_w (
        .clk(clk), .rst(w_rst), .valid_i(w_valid), .ready_o(w_ready), .pc_i(w_pc),
        .instr_i(w_instr), .alures_i(w_alu), .lsres_valid_i(w_lsv),
        .lsres_i(w_lsres), .rd_idx_o(w_idx), .rd_wren_o(w_wren),
        .rd_data_o(w_data), .retire_o(w_retire), .illegal_o(w_illegal),
        .instret_o(w_instret)
`ifdef DIFFTEST_EN
        , .commit_valid_o(w_cv), .commit_pc_o(w_cpc),
        .commit_instr_o(w_cinstr), .commit_rd_o(w_crd),
        .commit_data_o(w_cdata)
`endif
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
        mk = {20'h00000, rd, op, 2'b11};
    endfunction

    function automatic bit writes_reg(input logic [4:0] op);
        case (op)
            5'b01100, 5'b01110, 5'b00100, 5'b00110, 5'b11011,
            5'b11001, 5'b01101, 5'b00101, 5'b00000: writes_reg = 1'b1;
            default:                                writes_reg = 1'b0;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [4:0] op);
        is_illegal = !writes_reg(op) && (op != 5'b01000) && (op != 5'b11000);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; lsres_valid_i = 1'b0;
        pc_i = '0; instr_i = '0; alures_i = '0; lsres_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
        total++; if (rd_wren_o !== 1'b0) begin bad++; $display("FAIL rst_wren got=%b exp=0", rd_wren_o); end
        total++; if (retire_o !== 1'b0 || illegal_o !== 1'b0) begin bad++; $display("FAIL rst_retire got=%b/%b exp=0/0", retire_o, illegal_o); end
        total++; if (rd_idx_o !== 5'd0 || rd_data_o !== 64'd0) begin bad++; $display("FAIL rst_rd got=%0d/%h exp=0/0", rd_idx_o, rd_data_o); end
        total++; if (instret_o !== 64'd0) begin bad++; $display("FAIL rst_instret got=%0d exp=0", instret_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid_i = 1'b1; instr_i = mk(5'b00100, 5'd5); alures_i = 64'h10; pc_i = 64'h1000;
        cyc();
        instr_i = mk(5'b01100, 5'd6); alures_i = 64'h20; pc_i = 64'h1004;
        total++; if (rd_wren_o !== 1'b1 || rd_idx_o !== 5'd5 || rd_data_o !== 64'h10) begin bad++; $display("FAIL b2b_first got=%b/%0d/%h exp=1/5/10", rd_wren_o, rd_idx_o, rd_data_o); end
        cyc();
        valid_i = 1'b0;
        total++; if (rd_wren_o !== 1'b1 || rd_idx_o !== 5'd6 || rd_data_o !== 64'h20) begin bad++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/6/20", rd_wren_o, rd_idx_o, rd_data_o); end
        cyc();
        total++; if (instret_o !== 64'd2 || retire_o !== 1'b0) begin bad++; $display("FAIL b2b_instret got=%0d/%b exp=2/0", instret_o, retire_o); end
    endtask

    task automatic test_load_wait();
        do_reset();
        valid_i = 1'b1; instr_i = mk(5'b00000, 5'd7);
        cyc();
        valid_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                lsres_valid_i = 1'b1; lsres_i = 64'hDEAD;
                valid_i = 1'b1; instr_i = mk(5'b00100, 5'd10); alures_i = 64'h77;
            end
            total++; if (ready_o !== 1'b0 || retire_o !== 1'b0) begin bad++; $display("FAIL ldw_wait c%0d got=%b/%b exp=0/0", c, ready_o, retire_o); end
            cyc();
        end
        lsres_valid_i = 1'b0;
        total++; if (rd_wren_o !== 1'b1 || rd_idx_o !== 5'd7 || rd_data_o !== 64'hDEAD) begin bad++; $display("FAIL ldw_write got=%b/%0d/%h exp=1/7/dead", rd_wren_o, rd_idx_o, rd_data_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL ldw_ready got=%b exp=1", ready_o); end
        cyc();
        valid_i = 1'b0;
        total++; if (rd_wren_o !== 1'b1 || rd_idx_o !== 5'd10 || rd_data_o !== 64'h77) begin bad++; $display("FAIL ldw_next got=%b/%0d/%h exp=1/10/77", rd_wren_o, rd_idx_o, rd_data_o); end
        cyc();
        total++; if (instret_o !== 64'd2) begin bad++; $display("FAIL ldw_instret got=%0d exp=2", instret_o); end
    endtask

    task automatic test_same_cycle_load();
        do_reset();
        valid_i = 1'b1; instr_i = mk(5'b00000, 5'd8); lsres_valid_i = 1'b1; lsres_i = 64'h55;
        cyc();
        idle_inputs();
        total++; if (rd_wren_o !== 1'b1 || rd_idx_o !== 5'd8 || rd_data_o !== 64'h55 || ready_o !== 1'b1) begin bad++; $display("FAIL ld_same got=%b/%0d/%h/%b exp=1/8/55/1", rd_wren_o, rd_idx_o, rd_data_o, ready_o); end
        cyc();
        total++; if (retire_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL ld_same_after got=%b/%b exp=0/1", retire_o, ready_o); end
    endtask

    task automatic test_no_write();
        logic [31:0] seq [4];
        seq[0] = mk(5'b01000, 5'd3);
        seq[1] = mk(5'b11000, 5'd4);
        seq[2] = mk(5'b00100, 5'd0);
        seq[3] = mk(5'b11100, 5'd5);
        do_reset();
        valid_i = 1'b1; instr_i = seq[0]; alures_i = 64'hAB;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k < 3) instr_i = seq[k+1]; else valid_i = 1'b0;
            total++; if (retire_o !== 1'b1 || rd_wren_o !== 1'b0) begin bad++; $display("FAIL nowr_%0d got=%b/%b exp=1/0", k, retire_o, rd_wren_o); end
            total++; if (illegal_o !== (k == 3)) begin bad++; $display("FAIL nowr_ill_%0d got=%b exp=%b", k, illegal_o, (k == 3)); end
        end
        total++; if (instret_o !== 64'd3) begin bad++; $display("FAIL nowr_instret3 got=%0d exp=3", instret_o); end
        cyc();
        total++; if (instret_o !== 64'd4 || illegal_o !== 1'b0) begin bad++; $display("FAIL nowr_instret4 got=%0d/%b exp=4/0", instret_o, illegal_o); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        valid_i = 1'b1; instr_i = mk(5'b00000, 5'd9);
        cyc();
        valid_i = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; lsres_valid_i = 1'b1; lsres_i = 64'hBEEF;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rstw_ready got=%b exp=1", ready_o); end
        cyc();
        lsres_valid_i = 1'b0;
        total++; if (retire_o !== 1'b0 || rd_wren_o !== 1'b0 || instret_o !== 64'd0) begin bad++; $display("FAIL rstw_drop got=%b/%b/%0d exp=0/0/0", retire_o, rd_wren_o, instret_o); end
    endtask

    task automatic test_wrap();
        w_rst = 1'b1;
        cyc(); cyc();
        w_rst = 1'b0; w_valid = 1'b1; w_instr = mk(5'b00100, 5'd1); w_alu = 8'h3C; w_pc = 8'h40;
        for (int i = 0; i < 255; i++) cyc();
        w_valid = 1'b0;
        cyc();
        total++; if (w_instret !== 8'hFF) begin bad++; $display("FAIL wrap_max got=%h exp=ff", w_instret); end
        w_valid = 1'b1;
        cyc();
        w_valid = 1'b0;
        total++; if (w_retire !== 1'b1) begin bad++; $display("FAIL wrap_retire got=%b exp=1", w_retire); end
`ifdef DIFFTEST_EN
        total++; if (w_cv !== 1'b1 || w_cpc !== 8'h40 || w_cinstr !== mk(5'b00100, 5'd1)) begin bad++; $display("FAIL wrap_commit got=%b/%h/%h", w_cv, w_cpc, w_cinstr); end
`endif
        cyc();
        total++; if (w_instret !== 8'h00) begin bad++; $display("FAIL wrap_zero got=%h exp=00", w_instret); end
    endtask

    task automatic test_random();
        logic [4:0]  ops [14];
        bit          m_wait, m_ret;
        logic [31:0] m_hold_instr, m_ret_instr;
        logic [63:0] m_hold_pc, m_ret_pc, m_ret_data, m_instret;
        logic [4:0]  op;
        bit          exp_wren;
        ops = '{5'b01100, 5'b01110, 5'b00100, 5'b00110, 5'b11011, 5'b11001, 5'b01101,
                5'b00101, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b11000, 5'b10110};
        do_reset();
        m_wait = 1'b0; m_ret = 1'b0; m_instret = '0;
        m_hold_instr = '0; m_hold_pc = '0; m_ret_instr = '0; m_ret_pc = '0; m_ret_data = '0;
        for (int n = 0; n < 600; n++) begin
            exp_wren = m_ret && writes_reg(m_ret_instr[6:2]) && (m_ret_instr[11:7] != 5'd0);
            total++; if (ready_o !== !m_wait || retire_o !== m_ret) begin bad++; $display("FAIL rnd_hs n=%0d got=%b/%b exp=%b/%b", n, ready_o, retire_o, !m_wait, m_ret); end
            total++; if (rd_wren_o !== exp_wren || illegal_o !== (m_ret && is_illegal(m_ret_instr[6:2]))) begin bad++; $display("FAIL rnd_ctl n=%0d got=%b/%b exp=%b", n, rd_wren_o, illegal_o, exp_wren); end
            if (exp_wren) begin
                total++; if (rd_idx_o !== m_ret_instr[11:7] || rd_data_o !== m_ret_data) begin bad++; $display("FAIL rnd_data n=%0d got=%0d/%h exp=%0d/%h", n, rd_idx_o, rd_data_o, m_ret_instr[11:7], m_ret_data); end
            end else if (!m_ret) begin
                total++; if (rd_data_o !== 64'd0) begin bad++; $display("FAIL rnd_zero n=%0d got=%h exp=0", n, rd_data_o); end
            end
            total++; if (instret_o !== m_instret) begin bad++; $display("FAIL rnd_instret n=%0d got=%0d exp=%0d", n, instret_o, m_instret); end
`ifdef DIFFTEST_EN
            total++; if (commit_valid_o !== m_ret || commit_pc_o !== (m_ret ? m_ret_pc : 64'd0) || commit_instr_o !== (m_ret ? m_ret_instr : 32'd0)) begin bad++; $display("FAIL rnd_commit n=%0d got=%b/%h/%h", n, commit_valid_o, commit_pc_o, commit_instr_o); end
`endif
            valid_i       = ($urandom_range(0, 9) < 7);
            lsres_valid_i = ($urandom_range(0, 9) < 4);
            op            = ops[$urandom_range(0, 13)];
            instr_i       = {$urandom_range(0, 20'hFFFFF), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), op, 2'b11};
            pc_i          = {$urandom, $urandom};
            alures_i      = {$urandom, $urandom};
            lsres_i       = {$urandom, $urandom};
            m_instret = m_instret + (m_ret ? 64'd1 : 64'd0);
            if (m_wait) begin
                m_ret = lsres_valid_i;
                if (lsres_valid_i) begin
                    m_wait = 1'b0; m_ret_instr = m_hold_instr; m_ret_pc = m_hold_pc; m_ret_data = lsres_i;
                end
            end else if (valid_i) begin
                if (op == 5'b00000 && !lsres_valid_i) begin
                    m_wait = 1'b1; m_ret = 1'b0; m_hold_instr = instr_i; m_hold_pc = pc_i;
                end else begin
                    m_ret = 1'b1; m_ret_instr = instr_i; m_ret_pc = pc_i;
                    m_ret_data = (op == 5'b00000) ? lsres_i : alures_i;
                end
            end else begin
                m_ret = 1'b0;
            end
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        w_rst = 1'b1; w_valid = 1'b0; w_lsv = 1'b0;
        w_pc = '0; w_instr = '0; w_alu = '0; w_lsres = '0;
        test_reset();
        test_back_to_back();
        test_load_wait();
        test_same_cycle_load();
        test_no_write();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
